// File: rtl/clock_pkg.sv
// Shared types, limits and BCD increment helpers for the digital clock.
package clock_pkg;

  typedef logic [3:0] bcd_t;

  typedef struct packed {
    bcd_t tens;
    bcd_t units;
  } bcd_pair_t;

  localparam int   SEC_MAX             = 59;
  localparam int   MIN_TENS_MAX        = 5;
  localparam int   HR_TENS_MAX         = 2;
  localparam int   HR_UNITS_MAX_AT_TOP = 3;
  localparam bcd_t BCD_UNITS_MAX       = 4'd9;

  function automatic logic min_at_max(input bcd_pair_t m);
    return (m.tens == bcd_t'(MIN_TENS_MAX)) && (m.units == BCD_UNITS_MAX);
  endfunction

  // Minutes advance modulo 60; the caller decides whether 59->00 carries.
  function automatic bcd_pair_t min_next(input bcd_pair_t m);
    bcd_pair_t r;
    r = m;
    if (m.units == BCD_UNITS_MAX) begin
      r.units = '0;
      r.tens  = (m.tens == bcd_t'(MIN_TENS_MAX)) ? '0 : m.tens + 4'd1;
    end else begin
      r.units = m.units + 4'd1;
    end
    return r;
  endfunction

  function automatic bcd_pair_t hr_next(input bcd_pair_t h);
    bcd_pair_t r;
    r = h;
    if ((h.tens == bcd_t'(HR_TENS_MAX)) && (h.units == bcd_t'(HR_UNITS_MAX_AT_TOP))) begin
      r = '0;
    end else if (h.units == BCD_UNITS_MAX) begin
      r.units = '0;
      r.tens  = h.tens + 4'd1;
    end else begin
      r.units = h.units + 4'd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/tick_gen.sv
// Prescaler dividing clk down to a 1 Hz tick, plus the 50 % duty colon blink.
module tick_gen #(
  parameter int CLK_HZ = 100_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en_i,
  input  logic clr_i,
  output logic wrap_o,
  output logic tick_o,
  output logic colon_o
);

  localparam int           W    = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [W-1:0] TC   = W'(CLK_HZ - 1);
  localparam logic [W-1:0] HALF = W'(CLK_HZ / 2);

  logic [W-1:0] cnt_q, cnt_d;
  logic         tick_q, colon_q;

  // wrap_o is combinational so the time digits update on the same edge as tick_o.
  assign wrap_o = en_i && !clr_i && (cnt_q == TC);

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = (cnt_q == TC) ? '0 : cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      tick_q  <= 1'b0;
      colon_q <= 1'b1;
    end else begin
      cnt_q   <= cnt_d;
      tick_q  <= wrap_o;
      colon_q <= (cnt_d < HALF);
    end
  end

  assign tick_o  = tick_q;
  assign colon_o = colon_q;

endmodule

// File: rtl/bcd_time_keeper.sv
// 24-hour BCD timekeeper: seconds/minutes/hours cascade plus button-driven time setting.
module bcd_time_keeper
  import clock_pkg::*;
#(
  parameter int CLK_HZ = 100_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  input  logic set_mode,
  input  logic inc_min,
  input  logic inc_hr,
  output bcd_t min,
  output bcd_t min2,
  output bcd_t hr1,
  output bcd_t hr2,
  output logic sec_tick,
  output logic colon
);

  logic      wrap;
  logic [5:0] sec_q, sec_d;
  bcd_pair_t mins_q, mins_d;
  bcd_pair_t hrs_q, hrs_d;

  tick_gen #(.CLK_HZ(CLK_HZ)) u_tick_gen (
    .clk    (clk),
    .rst_n  (rst_n),
    .en_i   (run && !set_mode),
    .clr_i  (set_mode),
    .wrap_o (wrap),
    .tick_o (sec_tick),
    .colon_o(colon)
  );

  // wrap is never true in set mode, so the tick and set branches are exclusive.
  always_comb begin
    sec_d  = sec_q;
    mins_d = mins_q;
    hrs_d  = hrs_q;
    if (wrap) begin
      if (sec_q == 6'(SEC_MAX)) begin
        sec_d  = '0;
        mins_d = min_next(mins_q);
        if (min_at_max(mins_q)) begin
          hrs_d = hr_next(hrs_q);
        end
      end else begin
        sec_d = sec_q + 6'd1;
      end
    end else if (set_mode) begin
      if (inc_min) begin
        sec_d  = '0;
        mins_d = min_next(mins_q);
      end
      if (inc_hr) begin
        hrs_d = hr_next(hrs_q);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sec_q  <= '0;
      mins_q <= '0;
      hrs_q  <= '0;
    end else begin
      sec_q  <= sec_d;
      mins_q <= mins_d;
      hrs_q  <= hrs_d;
    end
  end

  assign min  = mins_q.units;
  assign min2 = mins_q.tens;
  assign hr1  = hrs_q.units;
  assign hr2  = hrs_q.tens;

endmodule

// File: doc/bcd_time_keeper.md
# bcd_time_keeper

- Timekeeping core of the digital clock.
- Divides the system clock down to a 1 Hz tick and counts seconds, minutes and hours in 24-hour BCD, from 00:00:00 to 23:59:59.
- Drives the four BCD digits consumed directly by the seven-segment decoder stage.
- Accepts single-cycle increment pulses from the debounced push-button stage for setting the time.

## Interface
- CLK_HZ, 100_000_000, system clock frequency; the prescaler terminal count is CLK_HZ-1. Benches override it to a small value.
- clk  in  1  system clock; all state changes on the rising edge.
- rst_n  in  1  reset, asynchronous and active-low.
- run  in  1  level; 1 = timekeeping enabled, 0 = prescaler and time frozen.
- set_mode  in  1  level; 1 = time-set mode: prescaler held at 0, no ticks, increment pulses honoured.
- inc_min  in  1  single-cycle pulse, synchronous to clk; advance minutes.
- inc_hr  in  1  single-cycle pulse, synchronous to clk; advance hours.
- min  out  4  minutes units digit, BCD 0-9.
- min2  out  4  minutes tens digit, BCD 0-5.
- hr1  out  4  hours units digit, BCD 0-9 (0-3 when hr2=2).
- hr2  out  4  hours tens digit, BCD 0-2.
- sec_tick  out  1  one-cycle pulse per counted second.
- colon  out  1  1 Hz blink, 50 % duty, for the display colon.

## Operation
- Reset (asynchronous assert, synchronous release) forces:
  - prescaler = 0, seconds = 0;
  - min = min2 = hr1 = hr2 = 0;
  - sec_tick = 0, colon = 1.
- Prescaler:
  - Increments when run=1 and set_mode=0.
  - At CLK_HZ-1 it wraps to 0 and generates a tick.
  - Holds its value when run=0.
  - Is forced to 0 when set_mode=1.
- On a tick, seconds increments 0-59.
- 59→0 carries into minutes:
  - min 9→0 carries into min2;
  - min2:min 59→00 carries into hours.
- Hours wrap: hr1 9→0 with hr2+1; 23→00 (hr2=2, hr1=3 → both 0).
- colon = 1 while prescaler < CLK_HZ/2, else 0. It is registered and frozen with the prescaler.
- Set mode (inc pulses are ignored when set_mode=0):
  - inc_min: minutes +1 modulo 60 with no hour carry; seconds cleared to 0.
  - inc_hr: hours +1 modulo 24; minutes and seconds untouched.
  - inc_min and inc_hr in the same cycle: both apply independently.
- Ticks and increments cannot coincide, because set_mode=1 suppresses ticks.
- Dropping set_mode restarts counting from prescaler 0, so the first tick arrives CLK_HZ cycles later.
- Outputs never hold illegal BCD. The downstream decoder's default pattern is unreachable from this block.

## Timing
- Prescaler = CLK_HZ-1 in cycle N with enables true → in cycle N+1:
  - sec_tick = 1;
  - seconds and digits show the updated value;
  - prescaler = 0.
- inc pulse sampled in cycle N → digits updated in cycle N+1. Latency 1, all outputs registered.
- A cascaded carry (e.g. 23:59:59→00:00:00) completes in a single edge; there are no intermediate values.
- Reset asserted mid-count clears immediately, with no clock needed. The first tick after release arrives CLK_HZ cycles after the first enabled edge.

## Structure
- Shared package clock_pkg holds:
  - the 4-bit BCD digit typedef;
  - constants SEC_MAX=59, MIN_TENS_MAX=5, HR_TENS_MAX=2, HR_UNITS_MAX_AT_TOP=3.
- One sub-module, tick_gen, contains the parameterised prescaler with enable and clear, producing the tick and colon. Prescaler width is $clog2(CLK_HZ).
- BCD cascade and set logic live in the top module.

## Test plan
- CLK_HZ=10, reset then run=1 for 600 cycles → sec_tick pulses every 10 cycles; digits read 00:01 after exactly 60 ticks.
- Preload 23:59:59 via set_mode pulses plus ticks, then 1 tick → next cycle digits 00:00 and seconds 0 in a single step; colon period is 10 cycles.
- set_mode=1:
  - 61 inc_min pulses from 00:00 → 00:01, with no hour change;
  - 25 inc_hr pulses → hours 01;
  - inc_min and inc_hr in the same cycle at 09:59 → 10:00.
- set_mode=0 with inc_min/inc_hr pulses → digits unchanged.
- run=0 for 37 cycles mid-second → prescaler and colon frozen; the tick resumes 37 cycles late.
- rst_n low asynchronously mid-count at 12:34 → all digits 0 and colon=1 before the next edge; counting resumes cleanly after release.
